// File: rtl/parking_gate_detector_if.sv
// Sensor-side bundle for the parking gate front end: raw beam inputs in,
// cleaned levels and passage pulses out.
interface parking_gate_detector_if;
  logic outer;
  logic inner;
  logic outer_clean;
  logic inner_clean;
  logic enter;
  logic exit;
  logic busy;

  modport master (
    output outer, inner,
    input  outer_clean, inner_clean, enter, exit, busy
  );

  modport slave (
    input  outer, inner,
    output outer_clean, inner_clean, enter, exit, busy
  );
endinterface

// File: rtl/parking_gate_detector.sv
// Synchronises and debounces the outer/inner photo-sensor lines, then decodes
// full car passages into one-cycle enter/exit pulses for the occupancy counter.
module parking_gate_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    reset,
  parking_gate_detector_if.slave gate
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E1,
    S_E2,
    S_E3,
    S_X1,
    S_X2,
    S_X3,
    S_WAIT_CLEAR
  } state_t;

  // Channel 1 is outer, channel 0 is inner, so r_clean reads directly as P.
  logic [1:0]             w_raw;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [CW-1:0]          r_cnt  [2];
  logic [1:0]             r_clean;

  state_t r_state;
  state_t w_next_state;
  logic   w_enter_next;
  logic   w_exit_next;
  logic   r_enter;
  logic   r_exit;

  assign w_raw = {gate.outer, gate.inner};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        r_sync[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_clean <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], w_raw[c]};
        if (r_sync[c][SYNC_STAGES-1] == r_clean[c]) begin
          r_cnt[c] <= '0;
        end else if (r_cnt[c] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_clean[c] <= r_sync[c][SYNC_STAGES-1];
          r_cnt[c]   <= '0;
        end else begin
          r_cnt[c] <= r_cnt[c] + CW'(1);
        end
      end
    end
  end

  // Any two-bit jump of P is treated as an illegal passage and parked in
  // WAIT_CLEAR until both beams are clear again.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_enter_next = 1'b0;
    w_exit_next  = 1'b0;
    unique case (r_state)
      S_IDLE: case (r_clean)
        2'b10:   w_next_state = S_E1;
        2'b01:   w_next_state = S_X1;
        2'b11:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_E1: case (r_clean)
        2'b11:   w_next_state = S_E2;
        2'b00:   w_next_state = S_IDLE;
        2'b01:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_E2: case (r_clean)
        2'b01:   w_next_state = S_E3;
        2'b10:   w_next_state = S_E1;
        2'b00:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_E3: case (r_clean)
        2'b00: begin
          w_next_state = S_IDLE;
          w_enter_next = 1'b1;
        end
        2'b11:   w_next_state = S_E2;
        2'b10:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_X1: case (r_clean)
        2'b11:   w_next_state = S_X2;
        2'b00:   w_next_state = S_IDLE;
        2'b10:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_X2: case (r_clean)
        2'b10:   w_next_state = S_X3;
        2'b01:   w_next_state = S_X1;
        2'b00:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_X3: case (r_clean)
        2'b00: begin
          w_next_state = S_IDLE;
          w_exit_next  = 1'b1;
        end
        2'b11:   w_next_state = S_X2;
        2'b01:   w_next_state = S_WAIT_CLEAR;
        default: ;
      endcase
      S_WAIT_CLEAR: if (r_clean == 2'b00) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_enter <= w_enter_next;
      r_exit  <= w_exit_next;
    end
  end

  assign gate.outer_clean = r_clean[1];
  assign gate.inner_clean = r_clean[0];
  assign gate.enter       = r_enter;
  assign gate.exit        = r_exit;
  assign gate.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_parking_gate_detector.sv
// Directed bench for parking_gate_detector: expected pulses are queued when a
// passage is completed and matched against the DUT's enter/exit outputs.
module tb_parking_gate_detector;

  typedef enum int {EV_ENTER, EV_EXIT} ev_t;
  typedef struct {
    ev_t kind;
    int  cycle;
  } exp_t;

  localparam int LAT = 7;  // raw release to pulse, default parameters

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  parking_gate_detector_if gate ();

  parking_gate_detector #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .gate (gate.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs for the whole simulation, comparing every pulse to the queue head.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (gate.enter || gate.exit)) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {30'd0, gate.enter, gate.exit}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {30'd0, gate.enter, gate.exit},
                (e.kind == EV_ENTER) ? 32'd2 : 32'd1);
          check("pulse_cycle", cyc, e.cycle);
          check("busy_at_pulse", {31'd0, gate.busy}, 32'd0);
        end
      end
    end
  endtask

  // Drive raw levels, optionally queue the expected pulse, hold n cycles,
  // then confirm the filtered levels followed the raw ones.
  task automatic step(input logic o, input logic i, input int n, input int push);
    exp_t e;
    gate.outer = o;
    gate.inner = i;
    if (push != 0) begin
      e.kind  = (push == 1) ? EV_ENTER : EV_EXIT;
      e.cycle = cyc + LAT;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
    check("outer_clean", {31'd0, gate.outer_clean}, {31'd0, o});
    check("inner_clean", {31'd0, gate.inner_clean}, {31'd0, i});
  endtask

  task automatic check_busy(input string tag, input logic exp);
    check(tag, {31'd0, gate.busy}, {31'd0, exp});
  endtask

  task automatic full_entry();
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b1, 10, 0);
    step(1'b0, 1'b1, 10, 0);
    step(1'b0, 1'b0, 10, 1);
    check_busy("busy_after_entry", 1'b0);
  endtask

  task automatic full_exit();
    step(1'b0, 1'b1, 10, 0);
    step(1'b1, 1'b1, 10, 0);
    step(1'b1, 1'b0, 10, 0);
    step(1'b0, 1'b0, 10, 2);
    check_busy("busy_after_exit", 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {27'd0, gate.outer_clean, gate.inner_clean, gate.enter, gate.exit, gate.busy}, 32'd0);
  endtask

  initial begin
    gate.outer = 1'b0;
    gate.inner = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check_busy("reset_busy", 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Entry, then exit
    step(1'b1, 1'b0, 10, 0);
    check_busy("busy_in_e1", 1'b1);
    step(1'b1, 1'b1, 10, 0);
    step(1'b0, 1'b1, 10, 0);
    step(1'b0, 1'b0, 10, 1);
    check_busy("busy_after_entry1", 1'b0);
    full_exit();

    // Short glitch on outer must be rejected entirely
    for (int k = 0; k < 13; k++) begin
      gate.outer = (k < 3);
      @(posedge clk);
      #1;
      check("glitch_outer_clean", {31'd0, gate.outer_clean}, 32'd0);
      check_busy("glitch_busy", 1'b0);
    end

    // Backtrack: car backs out of the gate, then enters properly
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b1, 10, 0);
    step(1'b1, 1'b0, 10, 0);
    step(1'b0, 1'b0, 10, 0);
    check_busy("busy_after_backtrack", 1'b0);
    full_entry();

    // Simultaneous two-bit jump 10 -> 01 lands in WAIT_CLEAR
    step(1'b1, 1'b0, 10, 0);
    step(1'b0, 1'b1, 10, 0);
    check_busy("busy_wait_clear", 1'b1);
    step(1'b0, 1'b0, 10, 0);
    check_busy("busy_after_clear", 1'b0);
    full_exit();

    // Reset while in E2, release with beams still blocked
    step(1'b1, 1'b0, 10, 0);
    step(1'b1, 1'b1, 10, 0);
    check_busy("busy_in_e2", 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset_outputs");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_busy("busy_after_reset_11", 1'b1);
    check("post_reset_clean", {30'd0, gate.outer_clean, gate.inner_clean}, 32'd3);
    step(1'b0, 1'b0, 10, 0);
    check_busy("busy_after_reset_clear", 1'b0);
    full_entry();

    repeat (10) @(posedge clk);
    #1;
    check("pending_pulses", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
